// File: rtl/firebird_mc_cu_pkg.sv
// firebird_pkg: shared definitions for the Firebird multi-cycle control unit.
//   state_e      : FSM state encodings (also exported on the debug state port)
//   OP_*         : RV32I major opcodes handled by the dispatcher
//   ALU_OP_*, SRC_A_*, SRC_B_*, PC_SRC_*, WB_SEL_* : datapath select codes
//   ctrl_t       : bundle of every control output, built per state
package firebird_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_LUI = 4'd4,
    S_ADDR     = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       old_pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/firebird_mc_cu_if.sv
// firebird_mc_cu_if: control-unit <-> datapath/memory bundle.
//   master : control unit side (consumes opcode/mem_ready/branch_taken,
//            drives selects, enables, debug state and sticky flags)
//   slave  : datapath side (mirror image)
interface firebird_mc_cu_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       pc_write;
  logic       old_pc_write;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic [3:0] state;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  opcode, mem_ready, branch_taken,
    output pc_write, old_pc_write, ir_write, iord, mem_read, mem_write,
           pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
           state, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready, branch_taken,
    input  pc_write, old_pc_write, ir_write, iord, mem_read, mem_write,
           pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
           state, illegal_op, mem_timeout
  );
endinterface

// File: rtl/firebird_mc_cu_dispatch.sv
// firebird_mc_cu_dispatch: combinational opcode -> post-DECODE state map.
//   i_opcode  : instr[6:0]
//   o_next    : state to enter after DECODE
//   o_illegal : opcode is not supported (o_next is S_TRAP)
module firebird_mc_cu_dispatch
  import firebird_pkg::*;
(
  input  logic [6:0] i_opcode,
  output state_e     o_next,
  output logic       o_illegal
);

  always_comb begin
    o_next    = S_TRAP;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R:               o_next = S_EXEC_R;
      OP_IMM:             o_next = S_EXEC_I;
      OP_LUI:             o_next = S_EXEC_LUI;
      // old_pc+imm is already in alu_out from DECODE; write it straight back
      OP_AUIPC:           o_next = S_WB_ALU;
      OP_LOAD, OP_STORE:  o_next = S_ADDR;
      OP_BRANCH:          o_next = S_BRANCH;
      OP_JAL:             o_next = S_JAL;
      OP_JALR:            o_next = S_JALR;
      default:            o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/firebird_mc_cu.sv
// firebird_mc_cu: multi-cycle Moore control unit for the Firebird core.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : firebird_mc_cu_if.master (opcode/mem_ready/branch_taken in,
//              datapath selects/enables, debug state and sticky flags out)
// Optional: define FIREBIRD_MC_CU_TIMEOUT_EN to trap after MEM_TIMEOUT+1
// consecutive memory wait cycles; otherwise memory waits are unbounded.
module firebird_mc_cu
  import firebird_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  firebird_mc_cu_if.master bus
);

  if ((2 ** TMO_W) <= MEM_TIMEOUT) begin : g_bad_tmo_w
    $error("TMO_W too narrow to hold MEM_TIMEOUT");
  end

  state_e r_state;
  state_e w_next;
  state_e w_disp_next;
  logic   w_disp_ill;
  logic   w_tmo_hit;
  logic   r_illegal;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  firebird_mc_cu_dispatch u_dispatch (
    .i_opcode  (bus.opcode),
    .o_next    (w_disp_next),
    .o_illegal (w_disp_ill)
  );

`ifdef FIREBIRD_MC_CU_TIMEOUT_EN
  logic             w_wait;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_mem_tmo;

  assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                   (r_state == S_MEM_WR)) && !bus.mem_ready;
  // the count reflects waits already elapsed, so the trap fires on wait
  // cycle MEM_TIMEOUT+1; a same-cycle mem_ready masks it via w_wait
  assign w_tmo_hit = w_wait && (r_tmo_cnt == TMO_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_mem_tmo <= 1'b0;
    end else begin
      r_tmo_cnt <= w_wait ? r_tmo_cnt + 1'b1 : '0;
      if (w_tmo_hit) r_mem_tmo <= 1'b1;
    end
  end

  assign bus.mem_timeout = r_mem_tmo & ~rst;
`else
  assign w_tmo_hit       = 1'b0;
  assign bus.mem_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_disp_ill) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
                  else if (w_tmo_hit) w_next = S_TRAP;
      S_DECODE:   w_next = w_disp_next;
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_LUI: w_next = S_WB_ALU;
      S_ADDR:     w_next = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) w_next = S_WB_MEM;
                  else if (w_tmo_hit) w_next = S_TRAP;
      S_MEM_WR:   if (bus.mem_ready) w_next = S_FETCH;
                  else if (w_tmo_hit) w_next = S_TRAP;
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_JAL,
      S_JALR:     w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.iord      = 1'b0;
        w_ctrl.alu_src_a = SRC_A_PC;
        w_ctrl.alu_src_b = SRC_B_FOUR;
        w_ctrl.alu_op    = ALU_OP_ADD;
        if (bus.mem_ready) begin
          w_ctrl.ir_write     = 1'b1;
          w_ctrl.pc_write     = 1'b1;
          w_ctrl.pc_src       = PC_SRC_ALU;
          w_ctrl.old_pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        // precompute old_pc+imm: branch/jal target and auipc result
        w_ctrl.alu_src_a = SRC_A_OLDPC;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_RS2;
        w_ctrl.alu_op    = ALU_OP_R;
      end
      S_EXEC_I: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.alu_op    = ALU_OP_I;
      end
      S_EXEC_LUI: begin
        w_ctrl.alu_src_a = SRC_A_ZERO;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      S_ADDR: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.mem_read = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      S_WB_ALU: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = WB_SEL_ALU;
      end
      S_WB_MEM: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = WB_SEL_MEM;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_RS2;
        w_ctrl.alu_op    = ALU_OP_BR;
        w_ctrl.pc_src    = PC_SRC_ALUOUT;
        w_ctrl.pc_write  = bus.branch_taken;
      end
      S_JAL: begin
        // rd gets the pre-update PC (already PC+4 from FETCH) = link address
        w_ctrl.pc_src     = PC_SRC_ALUOUT;
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = WB_SEL_PC;
      end
      S_JALR: begin
        w_ctrl.alu_src_a  = SRC_A_RS1;
        w_ctrl.alu_src_b  = SRC_B_IMM;
        w_ctrl.alu_op     = ALU_OP_ADD;
        w_ctrl.pc_src     = PC_SRC_ALU;
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = WB_SEL_PC;
      end
      default: w_ctrl = '0;
    endcase
  end

  assign w_out = rst ? '0 : w_ctrl;

  assign bus.pc_write     = w_out.pc_write;
  assign bus.old_pc_write = w_out.old_pc_write;
  assign bus.ir_write     = w_out.ir_write;
  assign bus.iord         = w_out.iord;
  assign bus.mem_read     = w_out.mem_read;
  assign bus.mem_write    = w_out.mem_write;
  assign bus.pc_src       = w_out.pc_src;
  assign bus.alu_src_a    = w_out.alu_src_a;
  assign bus.alu_src_b    = w_out.alu_src_b;
  assign bus.alu_op       = w_out.alu_op;
  assign bus.mem_to_reg   = w_out.mem_to_reg;
  assign bus.reg_write    = w_out.reg_write;
  assign bus.state        = r_state;
  assign bus.illegal_op   = r_illegal & ~rst;

endmodule

// File: tb/tb_firebird_mc_cu.sv
module tb_firebird_mc_cu;
  import firebird_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  firebird_mc_cu_if bus();

  firebird_mc_cu #(.MEM_TIMEOUT(3), .TMO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // per-cycle fields are packed LSB-first: cycle c is nibble/bit-pair c
  typedef struct {
    string       nm;
    logic [6:0]  op;
    logic        bt;
    int          len;
    logic [31:0] st;
    logic [7:0]  rdy;
    logic [7:0]  rw;
    logic [7:0]  pcw;
    logic [15:0] aop;
    logic [15:0] m2r;
    logic [15:0] psrc;
    logic [15:0] mem;   // {mem_write, mem_read}
  } vec_t;

  typedef struct {
    string      nm;
    int         cyc;
    logic [3:0] st;
    logic       rw;
    logic       pcw;
    logic [1:0] aop;
    logic [1:0] m2r;
    logic [1:0] psrc;
    logic [1:0] mem;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[10];

  function automatic logic [13:0] all_outs();
    return {bus.pc_write, bus.old_pc_write, bus.ir_write, bus.iord, bus.mem_read,
            bus.mem_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vt[0] = '{"r",      7'b0110011, 1'b0, 4, 32'h8210,    8'h0F, 8'b1000,    8'b0001, 16'h0020, 16'h0000, 16'h0000, 16'h0001};
    vt[1] = '{"opimm",  7'b0010011, 1'b0, 4, 32'h8310,    8'h0F, 8'b1000,    8'b0001, 16'h0030, 16'h0000, 16'h0000, 16'h0001};
    vt[2] = '{"lui",    7'b0110111, 1'b0, 4, 32'h8410,    8'h0F, 8'b1000,    8'b0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    vt[3] = '{"auipc_s",7'b0010111, 1'b0, 4, 32'h8100,    8'h0E, 8'b1000,    8'b0010, 16'h0000, 16'h0000, 16'h0000, 16'h0005};
    vt[4] = '{"load",   7'b0000011, 1'b0, 7, 32'h9666510, 8'h67, 8'b1000000, 8'b0000001, 16'h0000, 16'h1000, 16'h0000, 16'h0541};
    vt[5] = '{"store",  7'b0100011, 1'b0, 4, 32'h7510,    8'h0F, 8'b0000,    8'b0001, 16'h0000, 16'h0000, 16'h0000, 16'h0081};
    vt[6] = '{"br_t",   7'b1100011, 1'b1, 3, 32'hA10,     8'h07, 8'b000,     8'b101,  16'h0010, 16'h0000, 16'h0010, 16'h0001};
    vt[7] = '{"br_nt",  7'b1100011, 1'b0, 3, 32'hA10,     8'h07, 8'b000,     8'b001,  16'h0010, 16'h0000, 16'h0010, 16'h0001};
    vt[8] = '{"jal",    7'b1101111, 1'b0, 3, 32'hB10,     8'h07, 8'b100,     8'b101,  16'h0000, 16'h0020, 16'h0010, 16'h0001};
    vt[9] = '{"jalr",   7'b1100111, 1'b0, 3, 32'hC10,     8'h07, 8'b100,     8'b101,  16'h0000, 16'h0020, 16'h0000, 16'h0001};

    // reset: outputs forced low even though FETCH with mem_ready=1 would drive them
    rst = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 7'd0; bus.branch_taken = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_outs", 32'(all_outs()), 32'h0);
      chk("rst_wb", {28'h0, bus.mem_to_reg, bus.reg_write, bus.illegal_op | bus.mem_timeout}, 32'h0);
      chk("rst_state", 32'(bus.state), 32'd0);
      tick();
    end
    rst = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rel_state", 32'(bus.state), 32'd0);
    chk("rel_mem_read", 32'(bus.mem_read), 32'd1);
    chk("rel_ir_write", 32'(bus.ir_write), 32'd0);
    tick();

    // table-driven instruction sequences through the scoreboard
    for (int v = 0; v < 10; v++) begin
      for (int c = 0; c < vt[v].len; c++) begin
        bus.opcode = vt[v].op;
        bus.branch_taken = vt[v].bt;
        bus.mem_ready = vt[v].rdy[c];
        e.nm   = vt[v].nm;
        e.cyc  = c;
        e.st   = vt[v].st[4*c +: 4];
        e.rw   = vt[v].rw[c];
        e.pcw  = vt[v].pcw[c];
        e.aop  = vt[v].aop[2*c +: 2];
        e.m2r  = vt[v].m2r[2*c +: 2];
        e.psrc = vt[v].psrc[2*c +: 2];
        e.mem  = vt[v].mem[2*c +: 2];
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk($sformatf("%s[%0d].state", e.nm, e.cyc), 32'(bus.state), 32'(e.st));
        chk($sformatf("%s[%0d].ctl", e.nm, e.cyc),
            {21'h0, bus.reg_write, bus.pc_write, bus.alu_op, bus.mem_to_reg, bus.pc_src,
             bus.mem_write, bus.mem_read},
            {21'h0, e.rw, e.pcw, e.aop, e.m2r, e.psrc, e.mem});
        tick();
      end
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("end_fetch", 32'(bus.state), 32'd0);
    tick();

    // reset mid-instruction abandons it
    bus.opcode = 7'b0110011; bus.mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("mid_state", 32'(bus.state), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", 32'(all_outs()), 32'h0);
    tick();
    @(negedge clk);
    chk("mid_rst_state", 32'(bus.state), 32'd0);
    tick();
    rst = 1'b0;

    // illegal opcode traps and sticks
    bus.opcode = 7'b1111111; bus.mem_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("ill_decode", 32'(bus.state), 32'd1);
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ill_state", 32'(bus.state), 32'd13);
      chk("ill_flag", {30'h0, bus.illegal_op, bus.mem_timeout}, 32'h2);
      chk("ill_en", 32'(all_outs()), 32'h0);
      chk("ill_rw", 32'(bus.reg_write), 32'd0);
      tick();
    end
    rst = 1'b1; bus.mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ill_rst_state", 32'(bus.state), 32'd0);
    chk("ill_rst_flag", 32'(bus.illegal_op), 32'd0);
    tick();

`ifdef FIREBIRD_MC_CU_TIMEOUT_EN
    // MEM_TIMEOUT=3: fourth consecutive wait cycle in FETCH traps
    rst = 1'b1; bus.mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("tmo_pre_state", 32'(bus.state), 32'd0);
    chk("tmo_pre_flag", 32'(bus.mem_timeout), 32'd0);
    tick();
    @(negedge clk);
    chk("tmo_state", 32'(bus.state), 32'd13);
    chk("tmo_flags", {30'h0, bus.illegal_op, bus.mem_timeout}, 32'h1);
    tick();

    // ready on the would-be timeout cycle wins
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("tmo_win_state", 32'(bus.state), 32'd1);
    chk("tmo_win_flag", 32'(bus.mem_timeout), 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
